biquad_bank_scheduler: RTL and testbench

BIQUAD_BANK_SCHEDULER -- requirements
Module: biquad_bank_scheduler

---
 rtl/biquad_pkg.sv | 65 ++++++
 rtl/double_biquad.sv | 49 ++++
 rtl/biquad_bank_scheduler.sv | 171 +++++++++++++++++
 tb/tb_biquad_bank_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// ---------------------------------------------------------------------------
// biquad_pkg
// Shared types and helpers for the band-multiplexed double biquad.
//   coeff_set_t  : ten signed 32-bit coefficients for two cascaded sections
//   band_hist_t  : per-band history (section-0 output i, section-1 output y)
//   state_t      : scheduler FSM state
//   CI_*         : coefficient-select codes used on coeff_idx_in
//   mul64        : full-precision signed 32x32 -> 64 product
//   sat24        : clamp to the signed 24-bit range
// ---------------------------------------------------------------------------
package biquad_pkg;

   localparam logic [3:0] CI_B0_0 = 4'd0;
   localparam logic [3:0] CI_B1_0 = 4'd1;
   localparam logic [3:0] CI_B2_0 = 4'd2;
   localparam logic [3:0] CI_A1_0 = 4'd3;
   localparam logic [3:0] CI_A2_0 = 4'd4;
   localparam logic [3:0] CI_B0_1 = 4'd5;
   localparam logic [3:0] CI_B1_1 = 4'd6;
   localparam logic [3:0] CI_B2_1 = 4'd7;
   localparam logic [3:0] CI_A1_1 = 4'd8;
   localparam logic [3:0] CI_A2_1 = 4'd9;

   typedef struct packed {
      logic signed [31:0] b0_0;
      logic signed [31:0] b1_0;
      logic signed [31:0] b2_0;
      logic signed [31:0] a1_0;
      logic signed [31:0] a2_0;
      logic signed [31:0] b0_1;
      logic signed [31:0] b1_1;
      logic signed [31:0] b2_1;
      logic signed [31:0] a1_1;
      logic signed [31:0] a2_1;
   } coeff_set_t;

   typedef struct packed {
      logic signed [31:0] i1;
      logic signed [31:0] i2;
      logic signed [31:0] y1;
      logic signed [31:0] y2;
   } band_hist_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   function automatic logic signed [63:0] mul64(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
      logic signed [63:0] ae;
      logic signed [63:0] be;
      ae = {{32{a[31]}}, a};
      be = {{32{b[31]}}, b};
      return ae * be;
   endfunction

   function automatic logic signed [31:0] sat24(input logic signed [31:0] v);
      if (v > 32'sd8388607)       return 32'sd8388607;
      else if (v < -32'sd8388608) return -32'sd8388608;
      else                        return v;
   endfunction

endpackage

// File: rtl/double_biquad.sv
// ---------------------------------------------------------------------------
// double_biquad
// Combinational pair of cascaded direct-form-I biquad sections.
//   i[n] = (b0_0*x + b1_0*x1 + b2_0*x2 - a1_0*i1 - a2_0*i2) >>> SHIFT
//   y[n] = (b0_1*i + b1_1*i1 + b2_1*i2 - a1_1*y1 - a2_1*y2) >>> SHIFT
// Products and sums are 64-bit, shifted arithmetically and truncated to
// 32 bits (no rounding).
// Ports:
//   coeff_i         coefficient set of the band being computed
//   x_i, x1_i, x2_i input sample and its two predecessors
//   hist_i          the band's i/y history
//   i_n_o, y_n_o    section-0 and section-1 outputs
// ---------------------------------------------------------------------------
module double_biquad
   import biquad_pkg::*;
#(
   parameter int SHIFT = 20
) (
   input  coeff_set_t         coeff_i,
   input  logic signed [31:0] x_i,
   input  logic signed [31:0] x1_i,
   input  logic signed [31:0] x2_i,
   input  band_hist_t         hist_i,
   output logic signed [31:0] i_n_o,
   output logic signed [31:0] y_n_o
);

   logic signed [63:0] acc0;
   logic signed [63:0] acc1;
   logic signed [31:0] i_n;

   always_comb begin
      acc0 = mul64(coeff_i.b0_0, x_i)
           + mul64(coeff_i.b1_0, x1_i)
           + mul64(coeff_i.b2_0, x2_i)
           - mul64(coeff_i.a1_0, hist_i.i1)
           - mul64(coeff_i.a2_0, hist_i.i2);
      i_n  = 32'(acc0 >>> SHIFT);
      acc1 = mul64(coeff_i.b0_1, i_n)
           + mul64(coeff_i.b1_1, hist_i.i1)
           + mul64(coeff_i.b2_1, hist_i.i2)
           - mul64(coeff_i.a1_1, hist_i.y1)
           - mul64(coeff_i.a2_1, hist_i.y2);
   end

   assign i_n_o = i_n;
   assign y_n_o = 32'(acc1 >>> SHIFT);

endmodule

// File: rtl/biquad_bank_scheduler.sv
// ---------------------------------------------------------------------------
// biquad_bank_scheduler
// Time-multiplexes one double_biquad over NUM_BANDS bands. Every accepted
// sample is filtered by each band in turn, two cycles per band.
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   sample_in/_valid_in       new x[n]; sample_ready_out high only in IDLE
//   coeff_we_in/_band_in/_idx_in/_data_in  coefficient write (any state)
//   clear_state_in            zero all history (deferred while busy)
//   band_out/band_idx_out/band_valid_out   one band result per strobe
//   frame_done_out            strobes together with the last band
//   overrun_out               sample offered while busy (sample dropped)
// Optional build macro: BIQUAD_OUT_SAT_EN clamps band_out to signed 24 bits;
// stored y history stays unclamped.
//
// state   | meaning
// IDLE    | ready for a sample; applies pending/requested history clear
// CALC    | datapath evaluates current band, results registered
// EMIT    | band result presented; band history shifted; next band or IDLE
// ---------------------------------------------------------------------------
module biquad_bank_scheduler
   import biquad_pkg::*;
#(
   parameter int NUM_BANDS = 8,
   parameter int SHIFT     = 20
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic signed [31:0]           sample_in,
   input  logic                         sample_valid_in,
   output logic                         sample_ready_out,
   input  logic                         coeff_we_in,
   input  logic [$clog2(NUM_BANDS)-1:0] coeff_band_in,
   input  logic [3:0]                   coeff_idx_in,
   input  logic signed [31:0]           coeff_data_in,
   input  logic                         clear_state_in,
   output logic signed [31:0]           band_out,
   output logic [$clog2(NUM_BANDS)-1:0] band_idx_out,
   output logic                         band_valid_out,
   output logic                         frame_done_out,
   output logic                         overrun_out
);

   localparam int                 BW   = $clog2(NUM_BANDS);
   localparam logic [BW-1:0]      LAST = BW'(NUM_BANDS - 1);
   localparam logic signed [31:0] ONE  = 32'sd1 <<< SHIFT;

   coeff_set_t         coeff_q [NUM_BANDS];
   band_hist_t         hist_q  [NUM_BANDS];
   state_t             state_q;
   logic [BW-1:0]      band_q;
   logic signed [31:0] x_q, x1_q, x2_q;
   logic signed [31:0] i_n_q, y_n_q;
   logic               clear_pend_q;
   logic signed [31:0] band_out_q;
   logic [BW-1:0]      band_idx_q;
   logic               band_valid_q, frame_done_q;

   logic signed [31:0] i_n_d, y_n_d, out_d;

   double_biquad #(.SHIFT(SHIFT)) u_dp (
      .coeff_i (coeff_q[band_q]),
      .x_i     (x_q),
      .x1_i    (x1_q),
      .x2_i    (x2_q),
      .hist_i  (hist_q[band_q]),
      .i_n_o   (i_n_d),
      .y_n_o   (y_n_d)
   );

`ifdef BIQUAD_OUT_SAT_EN
   assign out_d = sat24(y_n_d);
`else
   assign out_d = y_n_d;
`endif

   // Coefficient bank; unity pass-through out of reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int b = 0; b < NUM_BANDS; b++) begin
            coeff_q[b]      <= '0;
            coeff_q[b].b0_0 <= ONE;
            coeff_q[b].b0_1 <= ONE;
         end
      end else if (coeff_we_in && (int'(coeff_band_in) < NUM_BANDS)) begin
         case (coeff_idx_in)
            CI_B0_0: coeff_q[coeff_band_in].b0_0 <= coeff_data_in;
            CI_B1_0: coeff_q[coeff_band_in].b1_0 <= coeff_data_in;
            CI_B2_0: coeff_q[coeff_band_in].b2_0 <= coeff_data_in;
            CI_A1_0: coeff_q[coeff_band_in].a1_0 <= coeff_data_in;
            CI_A2_0: coeff_q[coeff_band_in].a2_0 <= coeff_data_in;
            CI_B0_1: coeff_q[coeff_band_in].b0_1 <= coeff_data_in;
            CI_B1_1: coeff_q[coeff_band_in].b1_1 <= coeff_data_in;
            CI_B2_1: coeff_q[coeff_band_in].b2_1 <= coeff_data_in;
            CI_A1_1: coeff_q[coeff_band_in].a1_1 <= coeff_data_in;
            CI_A2_1: coeff_q[coeff_band_in].a2_1 <= coeff_data_in;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= ST_IDLE;
         band_q       <= '0;
         x_q          <= '0;
         x1_q         <= '0;
         x2_q         <= '0;
         i_n_q        <= '0;
         y_n_q        <= '0;
         clear_pend_q <= 1'b0;
         band_out_q   <= '0;
         band_idx_q   <= '0;
         band_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         for (int b = 0; b < NUM_BANDS; b++) hist_q[b] <= '0;
      end else begin
         band_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Clear lands at the same edge a sample is taken, so that
               // sample's first CALC already sees zeroed history.
               if (clear_state_in || clear_pend_q) begin
                  x1_q         <= '0;
                  x2_q         <= '0;
                  clear_pend_q <= 1'b0;
                  for (int b = 0; b < NUM_BANDS; b++) hist_q[b] <= '0;
               end
               if (sample_valid_in) begin
                  x_q     <= sample_in;
                  band_q  <= '0;
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (clear_state_in) clear_pend_q <= 1'b1;
               i_n_q        <= i_n_d;
               y_n_q        <= y_n_d;
               band_out_q   <= out_d;
               band_idx_q   <= band_q;
               band_valid_q <= 1'b1;
               frame_done_q <= (band_q == LAST);
               state_q      <= ST_EMIT;
            end
            ST_EMIT: begin
               if (clear_state_in) clear_pend_q <= 1'b1;
               hist_q[band_q] <= '{i1: i_n_q, i2: hist_q[band_q].i1,
                                   y1: y_n_q, y2: hist_q[band_q].y1};
               if (band_q == LAST) begin
                  x2_q    <= x1_q;
                  x1_q    <= x_q;
                  state_q <= ST_IDLE;
               end else begin
                  band_q  <= band_q + 1'b1;
                  state_q <= ST_CALC;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sample_ready_out = (state_q == ST_IDLE);
   assign overrun_out      = sample_valid_in && !sample_ready_out;
   assign band_out         = band_out_q;
   assign band_idx_out     = band_idx_q;
   assign band_valid_out   = band_valid_q;
   assign frame_done_out   = frame_done_q;

endmodule

// File: tb/tb_biquad_bank_scheduler.sv
module tb_biquad_bank_scheduler;

   localparam int NB = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [31:0] sample_in;
   logic               sample_valid_in;
   logic               sample_ready_out;
   logic               coeff_we_in;
   logic [2:0]         coeff_band_in;
   logic [3:0]         coeff_idx_in;
   logic signed [31:0] coeff_data_in;
   logic               clear_state_in;
   logic signed [31:0] band_out;
   logic [2:0]         band_idx_out;
   logic               band_valid_out;
   logic               frame_done_out;
   logic               overrun_out;

   biquad_bank_scheduler #(.NUM_BANDS(NB), .SHIFT(20)) dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .sample_in        (sample_in),
      .sample_valid_in  (sample_valid_in),
      .sample_ready_out (sample_ready_out),
      .coeff_we_in      (coeff_we_in),
      .coeff_band_in    (coeff_band_in),
      .coeff_idx_in     (coeff_idx_in),
      .coeff_data_in    (coeff_data_in),
      .clear_state_in   (clear_state_in),
      .band_out         (band_out),
      .band_idx_out     (band_idx_out),
      .band_valid_out   (band_valid_out),
      .frame_done_out   (frame_done_out),
      .overrun_out      (overrun_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int data;
      bit done;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   ev [NB];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string nm, input longint got, input longint want);
      n_total++;
      if (got == want) n_pass++;
      else $display("FAIL %s got=%0d required=%0d (t=%0t)", nm, got, want, $time);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && band_valid_out) begin
         if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid idx=%0d data=%0d required=no output", band_idx_out, band_out);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("band_idx", band_idx_out, e.idx);
            chk("band_out", band_out, e.data);
            chk("frame_done", frame_done_out, e.done);
            chk("valid_cycle", cyc, e.cyc);
         end
      end else if (rst_n && frame_done_out) begin
         chk("frame_done_without_valid", frame_done_out, 0);
      end
   end

   task automatic fill(input int v);
      for (int k = 0; k < NB; k++) ev[k] = v;
   endtask

   task automatic push_frame(input int t);
      for (int k = 0; k < NB; k++) begin
         exp_t e;
         e.idx  = k;
         e.data = ev[k];
         e.done = (k == NB - 1);
         e.cyc  = t + 1 + 2 * k;
         q.push_back(e);
      end
   endtask

   task automatic send(input int x, input bit clr);
      int n = 0;
      @(negedge clk);
      while (!sample_ready_out && n < 100) begin @(negedge clk); n++; end
      if (!sample_ready_out) chk("ready_timeout", sample_ready_out, 1);
      sample_in       = x;
      sample_valid_in = 1'b1;
      clear_state_in  = clr;
      @(posedge clk); #1;
      sample_valid_in = 1'b0;
      clear_state_in  = 1'b0;
      push_frame(cyc);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain_pending", q.size(), 0);
   endtask

   task automatic wr(input int b, input int idx, input int d);
      @(negedge clk);
      coeff_we_in   = 1'b1;
      coeff_band_in = b[2:0];
      coeff_idx_in  = idx[3:0];
      coeff_data_in = d;
      @(negedge clk);
      coeff_we_in   = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", sample_ready_out, 1);
      chk("rst_valid", band_valid_out, 0);
      chk("rst_done", frame_done_out, 0);
      chk("rst_band_out", band_out, 0);
      chk("rst_band_idx", band_idx_out, 0);
      chk("rst_overrun", overrun_out, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout cycles=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, ovr;
      rst_n = 1'b0;
      sample_in = '0; sample_valid_in = 1'b1; clear_state_in = 1'b0;
      coeff_we_in = 1'b0; coeff_band_in = '0; coeff_idx_in = '0; coeff_data_in = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      sample_valid_in = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Unity pass-through, latency and indices
      fill(1000); send(1000, 0); drain();

      // Band 3 gain 2 x 3
      wr(3, 0, 2 << 20); wr(3, 5, 3 << 20);
      fill(10); ev[3] = 60; send(10, 0); drain();
      wr(3, 0, 1 << 20); wr(3, 5, 1 << 20);

      // Feedback a1_0 = -0.5 on bands 0 and 7; clear in same cycle as impulse
      wr(0, 3, -(1 << 19)); wr(7, 3, -(1 << 19));
      fill(1024); send(1024, 1);
      fill(0); ev[0] = 512; ev[7] = 512; send(0, 0);
      ev[0] = 256; ev[7] = 256; send(0, 0);
      ev[0] = 128; ev[7] = 128; send(0, 0);
      drain();

      // Clear mid-frame: this frame unchanged, next frame fresh
      fill(0); ev[0] = 64; ev[7] = 64; send(0, 0);
      clear_state_in = 1'b1; @(posedge clk); #1; clear_state_in = 1'b0;
      fill(0); send(0, 0);
      fill(1024); send(1024, 0);
      drain();

      // Ignored indices, large gain on band 2 (saturation option)
      wr(1, 10, 5 << 20); wr(1, 15, 7 << 20); wr(2, 0, 16 << 20);
      fill(1 << 20);
`ifdef BIQUAD_OUT_SAT_EN
      ev[2] = 8388607;
`else
      ev[2] = 16777216;
`endif
      send(1 << 20, 1); drain();

      // Clear alone in IDLE, then valid held high for 20 cycles
      @(negedge clk); clear_state_in = 1'b1;
      @(negedge clk); clear_state_in = 1'b0;
      fill(0); acc = 0; ovr = 0;
      sample_in = 0; sample_valid_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (sample_ready_out) begin acc++; push_frame(cyc + 1); end
         if (overrun_out) ovr++;
         @(negedge clk);
      end
      sample_valid_in = 1'b0;
      chk("accepted_samples", acc, 2);
      chk("overrun_pulses", ovr, 18);
      drain();

      // Reset mid-frame aborts; coefficients and history return to reset
      fill(5); ev[2] = 80; send(5, 0);
      repeat (4) @(posedge clk); #1;
      rst_n = 1'b0;
      q.delete();
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_abort_queue", q.size(), 0);
      fill(1000); send(1000, 0); drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
